// File: rtl/imm_gen.sv
// RV32I immediate generator: decodes the opcode, assembles the I/S/B/U/J immediate
// and presents it on a registered output one clock after the instruction is sampled.
module imm_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [31:0] out
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0]  opcode;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] out_d;
    logic [31:0] out_q;

    assign opcode = instr[6:0];

    // All formats sign-extend from instr[31]; shift immediates take the full I value.
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        out_d = 32'h0000_0000;
        unique case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: out_d = imm_i;
            OPC_STORE:                                             out_d = imm_s;
            OPC_BRANCH:                                            out_d = imm_b;
            OPC_LUI, OPC_AUIPC:                                    out_d = imm_u;
            OPC_JAL:                                               out_d = imm_j;
            default:                                               out_d = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 32'h0000_0000;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed vectors, reset behaviour, latency and
// randomized instructions compared with an arithmetic reference model.
module tb_imm_gen;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    imm_gen dut (
        .clk   (clk),
        .rst   (rst),
        .instr (instr),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Reference: build each immediate as an integer value from named fields, then
    // apply two's-complement range by subtracting the sign weight.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        longint v;
        longint b31;
        logic [6:0] op;
        op  = w[6:0];
        b31 = longint'(w[31]);
        case (op)
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
                v = longint'(w[31:20]);
                if (b31 != 0) v = v - 4096;
            end
            7'h23: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (b31 != 0) v = v - 4096;
            end
            7'h63: begin
                v = b31 * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                    + longint'(w[11:8]) * 2;
                if (b31 != 0) v = v - 8192;
            end
            7'h37, 7'h17: v = longint'(w[31:12]) * 4096;
            7'h6F: begin
                v = b31 * (1 << 20) + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                    + longint'(w[30:21]) * 2;
                if (b31 != 0) v = v - (1 << 21);
            end
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    task automatic apply(input string tag, input logic [31:0] w, input logic [31:0] exp);
        @(negedge clk);
        instr = w;
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    logic [6:0] opcodes [0:11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                                   7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin
        logic [31:0] w;
        logic [31:0] prev;

        rst   = 1'b1;
        instr = 32'h7AAC6203;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", out, 32'h0);

        // First edge after deassertion loads the instruction present at that edge.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("deassert_load", out, 32'h000007AA);

        apply("load",   32'h7AAC6203, 32'h000007AA);
        apply("store",  32'hBAE98A23, 32'hFFFFFBB4);
        apply("branch", 32'h6719E063, 32'h00000660);
        apply("opimm",  32'hFF1E1813, 32'hFFFFFFF1);
        apply("jalr",   32'hFFC0C067, 32'hFFFFFFFC);
        apply("jal",    32'h0FFFC06F, 32'h000FC8FE);
        apply("lui",    32'h12345037, 32'h12345000);
        apply("auipc",  32'hFFFFF017, 32'hFFFFF000);
        apply("rtype",  32'h00B50533, 32'h00000000);
        apply("jal_neg", 32'h8000006F, 32'hFFF00000);
        apply("br_neg",  32'h80000063, 32'hFFFFF000);

        // Latency: a new instr between edges must not show until the next edge.
        apply("lat_pre", 32'h12345037, 32'h12345000);
        @(negedge clk);
        instr = 32'h7AAC6203;
        #2;
        check("lat_hold", out, 32'h12345000);
        @(posedge clk);
        #1;
        check("lat_next", out, 32'h000007AA);

        // Asynchronous reset between edges clears output without a clock edge.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_clear", out, 32'h0);
        @(posedge clk);
        #1;
        check("async_hold", out, 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        instr = 32'hFFC0C067;
        @(posedge clk);
        #1;
        check("async_release", out, 32'hFFFFFFFC);

        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            if (i % 8 != 7) w[6:0] = opcodes[$urandom_range(0, 11)];
            apply($sformatf("rand%0d_op%02h", i, w[6:0]), w, ref_imm(w));
        end

        prev = out;
        check("rand_stable", out, prev | ref_imm(instr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
